// File: rtl/rl02_pkg.sv
// Shared RL02 definitions: drive status word bit positions, the fault mask
// and the status receiver state encoding.
package rl02_pkg;

    localparam int ST_STATE_LSB  = 0;
    localparam int ST_BRUSH_HOME = 3;
    localparam int ST_HEADS_OUT  = 4;
    localparam int ST_COVER_OPEN = 5;
    localparam int ST_HEAD_SEL   = 6;
    localparam int ST_DRIVE_TYPE = 7;
    localparam int ST_DSE        = 8;
    localparam int ST_VC         = 9;
    localparam int ST_WGE        = 10;
    localparam int ST_SPE        = 11;
    localparam int ST_SKTO       = 12;
    localparam int ST_WL         = 13;
    localparam int ST_CHE        = 14;
    localparam int ST_WDE        = 15;

    // Write lock (bit 13) is a drive condition, not an error, so it stays out of the mask.
    localparam logic [15:0] DRIVE_FAULT_MASK = 16'hDF00;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_WAIT_START,
        RX_SHIFT,
        RX_DONE
    } rx_state_e;

    function automatic logic drive_fault_of(input logic [15:0] word);
        return |(word & DRIVE_FAULT_MASK);
    endfunction

endpackage

// File: rtl/rl02_status_receiver_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; STAGES must be at least 2.
// Resets to 0 so the synchronized level reads idle right after reset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rl02_status_receiver.sv
// RL02 Get Status receiver: waits for the drive's start bit, shifts in the
// 16-bit status word LSB first on drive_clock rises, and reports timeouts.
module rl02_status_receiver
    import rl02_pkg::*;
#(
    parameter int STATUS_BITS   = 16,
    parameter int TIMEOUT_DCLKS = 64,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   drive_clock_i,
    input  logic                   drive_status_i,
    input  logic                   status_request_i,
    output logic [STATUS_BITS-1:0] status_word_o,
    output logic                   status_valid_o,
    output logic                   status_busy_o,
    output logic                   status_timeout_o,
    output logic                   status_overrun_o,
    output logic                   drive_fault_o,
    output logic                   head_select_o
);

    localparam int TMO_W = (TIMEOUT_DCLKS > 1) ? $clog2(TIMEOUT_DCLKS) : 1;
    localparam int BIT_W = $clog2(STATUS_BITS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_DCLKS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(STATUS_BITS - 1);

    rx_state_e              state_q;
    logic                   drive_clock_q;
    logic                   status_line;
    logic                   dclk_rise;
    logic [BIT_W-1:0]       bit_cnt_q;
    logic [TMO_W-1:0]       tmo_cnt_q;
    logic [STATUS_BITS-1:0] shift_q;
    logic [STATUS_BITS-1:0] status_word_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   timeout_q;
    logic                   overrun_q;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_status_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (drive_status_i),
        .q_o   (status_line)
    );

    assign dclk_rise = drive_clock_i & ~drive_clock_q;

    // Receiver FSM; a request seen in any non-idle state (including the DONE
    // and timeout exit cycles) is dropped and only recorded as an overrun.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= RX_IDLE;
            drive_clock_q <= 1'b0;
            bit_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            shift_q       <= '0;
            status_word_q <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            drive_clock_q <= drive_clock_i;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;

            if (status_request_i && (state_q != RX_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                RX_IDLE: begin
                    if (status_request_i) begin
                        state_q   <= RX_WAIT_START;
                        bit_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                        overrun_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                RX_WAIT_START: begin
                    if (dclk_rise) begin
                        if (status_line) begin
                            state_q <= RX_SHIFT;
                        end else if (tmo_cnt_q == TMO_LAST) begin
                            state_q   <= RX_IDLE;
                            timeout_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else if (tmo_cnt_q != '1) begin
                            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        end
                    end
                end

                RX_SHIFT: begin
                    if (dclk_rise) begin
                        shift_q   <= {status_line, shift_q[STATUS_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= RX_DONE;
                        end
                    end
                end

                RX_DONE: begin
                    status_word_q <= shift_q;
                    valid_q       <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= RX_IDLE;
                end

                default: begin
                    state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign status_word_o    = status_word_q;
    assign status_valid_o   = valid_q;
    assign status_busy_o    = busy_q;
    assign status_timeout_o = timeout_q;
    assign status_overrun_o = overrun_q;
    assign drive_fault_o    = drive_fault_of(status_word_q);
    assign head_select_o    = status_word_q[ST_HEAD_SEL];

endmodule

// File: tb/tb_rl02_status_receiver.sv
// Directed bench for rl02_status_receiver: a table of status words plus
// hand-written timeout, overrun, reset and back-to-back sequences.
module tb_rl02_status_receiver;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        drive_clock_i;
    logic        drive_status_i = 1'b0;
    logic        status_request_i = 1'b0;
    logic [15:0] status_word_o;
    logic        status_valid_o;
    logic        status_busy_o;
    logic        status_timeout_o;
    logic        status_overrun_o;
    logic        drive_fault_o;
    logic        head_select_o;

    logic [3:0]  divCnt = 4'd0;
    int          assertCount = 0;
    int          failCount = 0;
    int          validCount = 0;
    int          dclkRises = 0;
    logic [15:0] lastWord = 16'h0000;

    typedef struct {
        logic [15:0] word;
        logic        expFault;
        logic        expHead;
    } vec_t;

    vec_t vecs[8];

    rl02_status_receiver dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .drive_clock_i    (drive_clock_i),
        .drive_status_i   (drive_status_i),
        .status_request_i (status_request_i),
        .status_word_o    (status_word_o),
        .status_valid_o   (status_valid_o),
        .status_busy_o    (status_busy_o),
        .status_timeout_o (status_timeout_o),
        .status_overrun_o (status_overrun_o),
        .drive_fault_o    (drive_fault_o),
        .head_select_o    (head_select_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive clock is clk/16, changing just after a clk rising edge like the sequencer's.
    always @(posedge clk_i) divCnt <= divCnt + 4'd1;
    assign drive_clock_i = divCnt[3];

    always @(negedge clk_i) begin
        if (status_valid_o) begin
            validCount++;
            lastWord = status_word_o;
        end
    end

    always @(posedge drive_clock_i) dclkRises++;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pulseRequest();
        @(negedge clk_i);
        status_request_i = 1'b1;
        @(negedge clk_i);
        status_request_i = 1'b0;
    endtask

    // Bits change mid-way between drive_clock rises so each is stable when sampled.
    task automatic sendWord(input logic [15:0] word, input bit reqOnDone);
        @(negedge drive_clock_i);
        @(negedge clk_i);
        drive_status_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge drive_clock_i);
            @(negedge clk_i);
            drive_status_i = word[i];
        end
        @(posedge drive_clock_i);
        @(negedge clk_i);
        if (reqOnDone) begin
            @(negedge clk_i);
            status_request_i = 1'b1;
            @(negedge clk_i);
            status_request_i = 1'b0;
        end
        @(negedge drive_clock_i);
        @(negedge clk_i);
        drive_status_i = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] word);
        pulseRequest();
        sendWord(word, 1'b0);
    endtask

    initial begin
        int v0;
        int r0;
        int rises;
        bit gotTmo;
        bit gotValid;

        vecs[0] = '{16'hA5C3, 1'b1, 1'b1};
        vecs[1] = '{16'h2000, 1'b0, 1'b0};
        vecs[2] = '{16'h0100, 1'b1, 1'b0};
        vecs[3] = '{16'h0040, 1'b0, 1'b1};
        vecs[4] = '{16'h4000, 1'b1, 1'b0};
        vecs[5] = '{16'h00BF, 1'b0, 1'b0};
        vecs[6] = '{16'h1000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 1'b1, 1'b0};

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("reset word", 32'(status_word_o), 32'h0);
        checkOutput("reset valid", 32'(status_valid_o), 32'h0);
        checkOutput("reset busy", 32'(status_busy_o), 32'h0);
        checkOutput("reset timeout", 32'(status_timeout_o), 32'h0);
        checkOutput("reset overrun", 32'(status_overrun_o), 32'h0);
        checkOutput("reset fault", 32'(drive_fault_o), 32'h0);

        for (int n = 0; n < 8; n++) begin
            v0 = validCount;
            applyStimulus(vecs[n].word);
            repeat (4) @(negedge clk_i);
            checkOutput($sformatf("vec%0d valid count", n), 32'(validCount - v0), 32'd1);
            checkOutput($sformatf("vec%0d word", n), 32'(status_word_o), 32'(vecs[n].word));
            checkOutput($sformatf("vec%0d fault", n), 32'(drive_fault_o), 32'(vecs[n].expFault));
            checkOutput($sformatf("vec%0d head", n), 32'(head_select_o), 32'(vecs[n].expHead));
            checkOutput($sformatf("vec%0d busy", n), 32'(status_busy_o), 32'h0);
            checkOutput($sformatf("vec%0d overrun", n), 32'(status_overrun_o), 32'h0);
        end

        // Timeout: line held low; the pulse must follow the 64th drive_clock rise.
        v0 = validCount;
        @(negedge clk_i);
        status_request_i = 1'b1;
        r0 = dclkRises;
        @(negedge clk_i);
        status_request_i = 1'b0;
        checkOutput("tmo busy while waiting", 32'(status_busy_o), 32'h1);
        gotTmo = 1'b0;
        rises = 0;
        for (int k = 0; k < 1500 && !gotTmo; k++) begin
            @(negedge clk_i);
            if (status_timeout_o) begin
                gotTmo = 1'b1;
                rises = dclkRises - r0;
            end
        end
        checkOutput("tmo pulse seen", 32'(gotTmo), 32'h1);
        checkOutput("tmo rise count", 32'(rises), 32'd64);
        checkOutput("tmo busy cleared", 32'(status_busy_o), 32'h0);
        checkOutput("tmo word kept", 32'(status_word_o), 32'h8000);
        @(negedge clk_i);
        checkOutput("tmo one-clk pulse", 32'(status_timeout_o), 32'h0);
        checkOutput("tmo no valid", 32'(validCount - v0), 32'd0);

        // Overrun: a second request in the middle of shifting 16'h0041.
        v0 = validCount;
        pulseRequest();
        fork
            sendWord(16'h0041, 1'b0);
            begin
                repeat (80) @(negedge clk_i);
                checkOutput("ovr busy mid-shift", 32'(status_busy_o), 32'h1);
                pulseRequest();
                checkOutput("ovr set", 32'(status_overrun_o), 32'h1);
            end
        join
        repeat (4) @(negedge clk_i);
        checkOutput("ovr valid count", 32'(validCount - v0), 32'd1);
        checkOutput("ovr word", 32'(status_word_o), 32'h0041);
        checkOutput("ovr sticky", 32'(status_overrun_o), 32'h1);
        checkOutput("ovr head", 32'(head_select_o), 32'h1);
        pulseRequest();
        checkOutput("ovr cleared by request", 32'(status_overrun_o), 32'h0);
        sendWord(16'h2000, 1'b0);
        repeat (4) @(negedge clk_i);
        checkOutput("ovr follow-up word", 32'(status_word_o), 32'h2000);

        // Reset in the middle of a word: partial data discarded immediately.
        pulseRequest();
        @(negedge drive_clock_i);
        @(negedge clk_i);
        drive_status_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge drive_clock_i);
            @(negedge clk_i);
            drive_status_i = (i % 2 == 0);
        end
        @(posedge drive_clock_i);
        repeat (2) @(negedge clk_i);
        checkOutput("rst busy before", 32'(status_busy_o), 32'h1);
        rst_i = 1'b1;
        #1;
        checkOutput("rst word", 32'(status_word_o), 32'h0);
        checkOutput("rst busy", 32'(status_busy_o), 32'h0);
        checkOutput("rst valid", 32'(status_valid_o), 32'h0);
        checkOutput("rst overrun", 32'(status_overrun_o), 32'h0);
        checkOutput("rst fault", 32'(drive_fault_o), 32'h0);
        @(negedge clk_i);
        drive_status_i = 1'b0;
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        v0 = validCount;
        applyStimulus(16'h0005);
        repeat (4) @(negedge clk_i);
        checkOutput("post-rst valid count", 32'(validCount - v0), 32'd1);
        checkOutput("post-rst word", 32'(status_word_o), 32'h0005);
        checkOutput("post-rst fault", 32'(drive_fault_o), 32'h0);

        // Back-to-back: request one clk after status_valid is accepted cleanly.
        v0 = validCount;
        pulseRequest();
        fork
            sendWord(16'h4321, 1'b0);
            begin
                gotValid = 1'b0;
                for (int k = 0; k < 400 && !gotValid; k++) begin
                    @(negedge clk_i);
                    if (status_valid_o) gotValid = 1'b1;
                end
                checkOutput("b2b first valid seen", 32'(gotValid), 32'h1);
                status_request_i = 1'b1;
                @(negedge clk_i);
                status_request_i = 1'b0;
                checkOutput("b2b accepted busy", 32'(status_busy_o), 32'h1);
                checkOutput("b2b no overrun", 32'(status_overrun_o), 32'h0);
            end
        join
        checkOutput("b2b first word", 32'(status_word_o), 32'h4321);

        // The second reception gets a request on its DONE clk: overrun, not queued.
        sendWord(16'h0C0C, 1'b1);
        repeat (4) @(negedge clk_i);
        checkOutput("done-req valid count", 32'(validCount - v0), 32'd2);
        checkOutput("done-req word", 32'(status_word_o), 32'h0C0C);
        checkOutput("done-req overrun", 32'(status_overrun_o), 32'h1);
        checkOutput("done-req not queued", 32'(status_busy_o), 32'h0);
        checkOutput("done-req fault", 32'(drive_fault_o), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
